spi_ram_responder: RTL and testbench
====================================

# spi_ram_responder

Synthesizable SPI SRAM responder, the slave end of the nanoV CPU's serial memory bus. It decodes READ (0x03) and WRITE (0x02) transactions with 24-bit addresses from the CPU's select, MOSI and clock-enable outputs, and serves them from a small internal byte array. It runs on the CPU's system clock, so the bench and on-chip test configurations need no external SPI RAM.

## Interface
- `ADDR_BITS`, default 8: internal array depth is 2^ADDR_BITS bytes; address bits above this are ignored.
- `clk` input 1: system clock, the same clock as the CPU. SPI clock is `!clk && spi_clk_enable`.
- `rstn` input 1: asynchronous, active-low reset.
- `spi_select` input 1: chip select, active low.
- `spi_clk_enable` input 1: high marks an SPI bit cycle.
- `spi_mosi` input 1: command, address and write data, MSB first.
- `spi_data_out` output 1: read data to the CPU's `spi_data_in`.
- `busy` output 1: high from the first bit cycle of a transaction until deselect.

## Operation
- A bit cycle is a `clk` cycle with `spi_select`=0 and `spi_clk_enable`=1. `spi_mosi` is sampled at the rising `clk` edge ending the bit cycle. Cycles with the enable low pause the transaction with all state held.
- State machine states: IDLE, CMD, ADDR, READ, WRITE, IGNORE.
  - IDLE → CMD on the first bit cycle.
  - CMD: shifts in 8 bits. After bit 7: 0x03 → ADDR(read), 0x02 → ADDR(write), any other value → IGNORE.
  - ADDR: shifts in 24 bits; the low ADDR_BITS are kept as `addr`. After bit 31 → READ or WRITE.
  - READ: streams `mem[addr]` MSB first. After each 8th data bit, `addr` = `addr`+1 modulo 2^ADDR_BITS (wraps to 0) and the next byte loads.
  - WRITE: shifts in 8 bits, then writes `mem[addr]` and increments `addr` with the same wrap. A partial byte at deselect is discarded.
  - IGNORE: no memory access; `spi_data_out` stays 0.
- `spi_select`=1 at any clock edge returns the block to IDLE, clears the bit counters and clears `busy`, whatever the current state.
- The memory array is not reset; its contents after reset are undefined. Registers are reset; `addr` resets to 0.
- Reset mid-transaction aborts it with no memory write.

## Timing
- Reset values: `spi_data_out`=0, `busy`=0, state=IDLE.
- `spi_data_out` is registered and changes only on rising `clk`.
- At the edge ending bit cycle 31 (the last address bit) of a READ, `spi_data_out` takes bit 7 of `mem[addr]`. It is therefore valid throughout data bit cycle 32. Each later bit-cycle edge presents the next bit.
- Read-to-byte latency is zero bit cycles: the first data bit cycle already carries valid data, with no dummy byte.
- `spi_data_out` is 0 in every state other than READ.
- A WRITE byte is committed at the edge ending its 8th data bit. A READ of that same address in a later transaction returns the new value.
- `busy` rises at the edge ending the first bit cycle and falls at the first edge with `spi_select`=1.
- A bit cycle and a deselect in the same cycle cannot occur, because a bit cycle requires `spi_select`=0.

## Structure
- Shared package `spi_ram_pkg` holds:
  - `CMD_READ`=8'h03 and `CMD_WRITE`=8'h02;
  - the state enum;
  - the 24-bit address width constant.
- Sub-module `spi_ram_array`: a single-port byte array with synchronous write and asynchronous read, parameterised by ADDR_BITS. The top-level FSM owns the shifters and counters.

## Test plan
- Reset: hold `rstn`=0 mid-stream, then release → `spi_data_out`=0, `busy`=0; the next transaction decodes from bit 0.
- Write then read: WRITE 0x02, addr 0x000010, data 0xA5 0x3C; deselect; READ 0x03, addr 0x000010 → 16 data bits on `spi_data_out` are 1010_0101_0011_1100, with first bit valid in bit cycle 32.
- Wrap (ADDR_BITS=8): WRITE at 0x0000FF with bytes 0x11 0x22 → `mem[0xFF]`=0x11 and `mem[0x00]`=0x22; READ at 0xFF over 2 bytes returns 0x11 then 0x22.
- Clock-enable pauses: READ with `spi_clk_enable` dropped for 3 cycles in the address and data phases → output bit sequence identical to the unpaused run, with each bit held during the pause.
- Unknown command 0x05 followed by 40 bits → `spi_data_out` stays 0, memory unchanged; `busy`=1 until deselect.
- Abort: WRITE with 5 data bits, then deselect → target byte unchanged; `busy` falls on the deselect edge; an immediate READ works normally.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI SRAM responder: command codes, FSM states
// and the serial address width.
package spi_ram_pkg;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam int         SPI_ADDR_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_READ,
    ST_WRITE,
    ST_IGNORE
  } spi_state_e;

endpackage

// File: rtl/spi_ram_array.sv
// Single-port byte array: synchronous write, asynchronous read, no reset.
module spi_ram_array #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata
);

  logic [7:0] mem_q [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/spi_ram_responder.sv
// SPI SRAM slave for the nanoV serial memory bus: decodes READ/WRITE with a
// 24-bit address and serves them from an internal byte array.
module spi_ram_responder
  import spi_ram_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       spi_select,
  input  logic       spi_clk_enable,
  input  logic       spi_mosi,
  output logic       spi_data_out,
  output logic       busy,
  output spi_state_e dbg_state
);

  // Shift register holds the command, the kept address bits, or the
  // remaining read bits (pre-shifted so bit 7 is always the next one out).
  localparam int SHIFT_W = (ADDR_BITS > 8) ? ADDR_BITS : 8;

  spi_state_e           state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 wr_q, wr_d;
  logic                 dout_q, dout_d;
  logic                 busy_q, busy_d;

  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [7:0]           mem_wdata;
  logic [7:0]           mem_rdata;
  logic [7:0]           cmd_byte;
  logic [ADDR_BITS-1:0] new_addr;

  assign cmd_byte = {shift_q[6:0], spi_mosi};
  assign new_addr = {shift_q[ADDR_BITS-2:0], spi_mosi};

  spi_ram_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    dout_d    = dout_q;
    busy_d    = busy_q;
    mem_we    = 1'b0;
    mem_wdata = cmd_byte;

    // Read port looks ahead: at the last address bit it sees the incoming
    // address, during a read it sees the following byte.
    case (state_q)
      ST_ADDR: mem_addr = new_addr;
      ST_READ: mem_addr = addr_q + ADDR_BITS'(1);
      default: mem_addr = addr_q;
    endcase

    if (spi_select) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
      dout_d  = 1'b0;
    end else if (spi_clk_enable) begin
      busy_d  = 1'b1;
      cnt_d   = cnt_q + 5'd1;
      shift_d = {shift_q[SHIFT_W-2:0], spi_mosi};
      dout_d  = 1'b0;
      case (state_q)
        ST_IDLE: state_d = ST_CMD;
        ST_CMD: begin
          if (cnt_q == 5'd7) begin
            cnt_d = '0;
            if (cmd_byte == CMD_READ) begin
              state_d = ST_ADDR;
              wr_d    = 1'b0;
            end else if (cmd_byte == CMD_WRITE) begin
              state_d = ST_ADDR;
              wr_d    = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR: begin
          if (cnt_q == 5'(SPI_ADDR_W - 1)) begin
            cnt_d  = '0;
            addr_d = new_addr;
            if (wr_q) begin
              state_d = ST_WRITE;
            end else begin
              state_d = ST_READ;
              dout_d  = mem_rdata[7];
              shift_d = SHIFT_W'({mem_rdata[6:0], 1'b0});
            end
          end
        end
        ST_READ: begin
          dout_d  = shift_q[7];
          shift_d = shift_q << 1;
          if (cnt_q == 5'd7) begin
            cnt_d   = '0;
            addr_d  = addr_q + ADDR_BITS'(1);
            dout_d  = mem_rdata[7];
            shift_d = SHIFT_W'({mem_rdata[6:0], 1'b0});
          end
        end
        ST_WRITE: begin
          if (cnt_q == 5'd7) begin
            cnt_d  = '0;
            mem_we = 1'b1;
            addr_d = addr_q + ADDR_BITS'(1);
          end
        end
        ST_IGNORE: cnt_d = cnt_q;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
    end
  end

  assign spi_data_out = dout_q;
  assign busy         = busy_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed plus randomized bench for spi_ram_responder against a byte-array
// reference model of the SPI RAM transaction rules.
module tb_spi_ram_responder;
  import spi_ram_pkg::*;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       spi_select = 1'b1;
  logic       spi_clk_enable = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_data_out;
  logic       busy;
  spi_state_e dbg_state;

  int n_pass = 0;
  int n_fail = 0;
  int n_checks = 0;

  logic [7:0] ref_mem [256];
  bit         ref_known [256];

  always #5 clk = ~clk;

  spi_ram_responder #(.ADDR_BITS(8)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .spi_select     (spi_select),
    .spi_clk_enable (spi_clk_enable),
    .spi_mosi       (spi_mosi),
    .spi_data_out   (spi_data_out),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    spi_select     = 1'b0;
    spi_clk_enable = 1'b1;
    spi_mosi       = b;
    tick();
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic deselect();
    spi_select     = 1'b1;
    spi_clk_enable = 1'b0;
    tick();
  endtask

  task automatic model_write(input logic [23:0] addr, input logic [7:0] b, input int i);
    int a;
    a = (int'(addr[7:0]) + i) % 256;
    ref_mem[a]   = b;
    ref_known[a] = 1'b1;
  endtask

  task automatic read_byte(output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      b[i] = spi_data_out;
      send_bit(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic read_check(input string tag, input logic [23:0] addr, input int n);
    logic [7:0] b;
    int a;
    send_bits({24'd0, CMD_READ}, 8);
    send_bits({8'd0, addr}, 24);
    for (int i = 0; i < n; i++) begin
      read_byte(b);
      a = (int'(addr[7:0]) + i) % 256;
      if (ref_known[a]) check(tag, b, ref_mem[a]);
    end
    deselect();
  endtask

  task automatic write_txn(input logic [23:0] addr, input logic [31:0] data, input int n);
    send_bits({24'd0, CMD_WRITE}, 8);
    send_bits({8'd0, addr}, 24);
    for (int i = 0; i < n; i++) begin
      send_bits({24'd0, data[8*(n-1-i) +: 8]}, 8);
      model_write(addr, data[8*(n-1-i) +: 8], i);
    end
    deselect();
  endtask

  initial begin
    logic [15:0] got16;
    logic [15:0] exp16;
    logic [7:0]  b;
    logic [23:0] ra;
    logic [31:0] rd;
    int          rn;
    logic        stuck;

    // Reset state
    repeat (3) tick();
    check("reset_dout", spi_data_out, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    rstn = 1'b1;
    tick();

    // Write A5 3C at 0x10; busy rises on the first bit-cycle edge
    check("busy_before_first_bit", busy, 1'b0);
    send_bit(1'b0);
    check("busy_after_first_bit", busy, 1'b1);
    send_bits(32'h02, 7);
    send_bits(32'h000010, 24);
    send_bits(32'hA53C, 16);
    model_write(24'h10, 8'hA5, 0);
    model_write(24'h10, 8'h3C, 1);
    check("busy_before_deselect", busy, 1'b1);
    deselect();
    check("busy_after_deselect", busy, 1'b0);

    // Read back 16 bits, first bit valid in bit cycle 32
    send_bits({24'd0, CMD_READ}, 8);
    send_bits(32'h000010, 24);
    for (int i = 15; i >= 0; i--) begin
      got16[i] = spi_data_out;
      send_bit(1'($urandom_range(0, 1)));
    end
    deselect();
    exp16 = {ref_mem[8'h10], ref_mem[8'h11]};
    check("write_read_a53c", got16, exp16);
    check("dout_idle_after_read", spi_data_out, 1'b0);

    // Address wrap at 0xFF; upper address bits are ignored
    ra = {16'($urandom), 8'hFF};
    write_txn(ra, 32'h1122, 2);
    read_check("wrap_read_ff", 24'h0000FF, 2);
    read_check("wrap_read_00", 24'h000000, 1);

    // Clock-enable pauses in address and data phases
    send_bits({24'd0, CMD_READ}, 8);
    send_bits(32'h000, 12);
    spi_clk_enable = 1'b0;
    stuck = 1'b0;
    repeat (3) begin
      tick();
      stuck = stuck | spi_data_out;
    end
    check("pause_addr_dout_low", stuck, 1'b0);
    send_bits(32'h010, 12);
    for (int i = 15; i >= 0; i--) begin
      if (i == 12) begin
        spi_clk_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          check("pause_data_hold", spi_data_out, exp16[12]);
        end
      end
      got16[i] = spi_data_out;
      send_bit(1'($urandom_range(0, 1)));
    end
    deselect();
    check("pause_read_a53c", got16, exp16);

    // Unknown command 0x05 then 40 bits: output stays low, busy held
    send_bits(32'h05, 8);
    stuck = 1'b0;
    for (int i = 0; i < 40; i++) begin
      send_bit(1'($urandom_range(0, 1)));
      stuck = stuck | spi_data_out;
    end
    check("unknown_dout_low", stuck, 1'b0);
    check("unknown_busy", busy, 1'b1);
    check("unknown_state", 32'(dbg_state), 32'(ST_IGNORE));
    deselect();
    check("unknown_busy_clear", busy, 1'b0);
    read_check("unknown_mem_intact", 24'h000010, 2);

    // Abort a partial write byte by deselect
    send_bits({24'd0, CMD_WRITE}, 8);
    send_bits(32'h000010, 24);
    send_bits(32'h1F, 5);
    check("abort_busy_before", busy, 1'b1);
    deselect();
    check("abort_busy_fell", busy, 1'b0);
    read_check("abort_byte_unchanged", 24'h000010, 1);

    // Reset mid-write: no commit, next transaction decodes from bit 0
    send_bits({24'd0, CMD_WRITE}, 8);
    send_bits(32'h000011, 24);
    send_bits(32'h0, 4);
    spi_clk_enable = 1'b0;
    rstn = 1'b0;
    tick();
    tick();
    check("midreset_dout", spi_data_out, 1'b0);
    check("midreset_busy", busy, 1'b0);
    rstn = 1'b1;
    tick();
    read_check("midreset_no_write", 24'h000011, 1);

    // Randomized writes and read-backs against the model
    for (int t = 0; t < 20; t++) begin
      ra = 24'($urandom);
      rd = $urandom;
      rn = $urandom_range(1, 3);
      write_txn(ra, rd, rn);
      read_check("rand_readback", ra, rn);
    end
    for (int t = 0; t < 6; t++) begin
      read_check("rand_stream", 24'($urandom), $urandom_range(2, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
